// File: rtl/dmem_arb_pkg.sv
// Shared constants for the data-memory arbiter.
//   - FSM state encoding: which requester (if any) was granted last cycle
//   - Requester IDs, also used as bit positions in the req/gnt vectors
//   - Hold-counter width and its saturating increment helper
package dmem_arb_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_OWN_CPU = 2'd1;
  localparam logic [1:0] ST_OWN_DMA = 2'd2;

  localparam logic ID_CPU = 1'b0;
  localparam logic ID_DMA = 1'b1;

  // Wide enough for the largest legal hold limit (15).
  localparam int unsigned HOLD_W = 4;

  function automatic logic [HOLD_W-1:0] hold_inc(input logic [HOLD_W-1:0] cnt,
                                                 input logic [HOLD_W-1:0] lim);
    return (cnt < lim) ? cnt + HOLD_W'(1) : cnt;
  endfunction

endpackage

// File: rtl/rr_hold_arbiter.sv
// Two-requester arbiter with bounded ownership.
// A lone requester is always granted. On a tie the current owner keeps the
// grant until it has held it MAX_HOLD consecutive cycles, then it passes to
// the other side; from idle a tie goes to whoever was not served last.
// Ports:
//   clk   - clock, all state on rising edge
//   reset - synchronous active-low reset; forces gnt to 0 while low
//   req   - request vector, bit ID_CPU / ID_DMA
//   gnt   - one-hot-or-zero grant vector, combinational from req and state
module rr_hold_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

  logic [1:0]        state_q, state_d;
  logic              last_q, last_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              winner;

  // Tie-break choice; only consulted when both requesters are active.
  always_comb begin
    winner = ~last_q;
    case (state_q)
      ST_OWN_CPU: winner = (hold_q < HOLD_MAX) ? ID_CPU : ID_DMA;
      ST_OWN_DMA: winner = (hold_q < HOLD_MAX) ? ID_DMA : ID_CPU;
      default:    winner = ~last_q;
    endcase
  end

  always_comb begin
    gnt = 2'b00;
    if (reset) begin
      if (req == 2'b11) begin
        gnt[winner] = 1'b1;
      end else begin
        gnt = req;
      end
    end
  end

  always_comb begin
    state_d = ST_IDLE;
    last_d  = last_q;
    hold_d  = '0;
    if (gnt[ID_CPU]) begin
      state_d = ST_OWN_CPU;
      last_d  = ID_CPU;
      hold_d  = (state_q == ST_OWN_CPU) ? hold_inc(hold_q, HOLD_MAX) : HOLD_W'(1);
    end else if (gnt[ID_DMA]) begin
      state_d = ST_OWN_DMA;
      last_d  = ID_DMA;
      hold_d  = (state_q == ST_OWN_DMA) ? hold_inc(hold_q, HOLD_MAX) : HOLD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      last_q  <= ID_DMA;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between a CPU and a DMA requester.
// Grants come from rr_hold_arbiter; this level muxes the granted request onto
// the memory port and returns read data one cycle after the grant.
// Ports:
//   clk, reset                        - clock, synchronous active-low reset
//   cpu_req/we/addr/wdata             - CPU request (we=1 write)
//   cpu_gnt, cpu_rvalid, cpu_rdata    - CPU grant and read response
//   dma_*                             - same set for the DMA requester
//   mem_rd, mem_wr, mem_addr, mem_wdata - memory command, zero when idle
//   mem_rdata                         - combinational read data of mem_addr
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_gnt,
  output logic          dma_rvalid,
  output logic [DW-1:0] dma_rdata,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  logic [1:0]    req;
  logic [1:0]    gnt;
  logic          cpu_rd_gnt, dma_rd_gnt;
  logic          cpu_rvalid_q, dma_rvalid_q;
  logic [DW-1:0] cpu_rdata_q, dma_rdata_q;

  assign req[ID_CPU] = cpu_req;
  assign req[ID_DMA] = dma_req;

  rr_hold_arbiter #(
    .MAX_HOLD(MAX_HOLD)
  ) u_arb (
    .clk  (clk),
    .reset(reset),
    .req  (req),
    .gnt  (gnt)
  );

  assign cpu_gnt    = gnt[ID_CPU];
  assign dma_gnt    = gnt[ID_DMA];
  assign cpu_rd_gnt = cpu_gnt & ~cpu_we;
  assign dma_rd_gnt = dma_gnt & ~dma_we;

  always_comb begin
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_rd    = ~cpu_we;
      mem_wr    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dma_gnt) begin
      mem_rd    = ~dma_we;
      mem_wr    = dma_we;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
    end
  end

  // Read data is captured at the grant edge and held until the next read.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cpu_rvalid_q <= 1'b0;
      dma_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
    end else begin
      cpu_rvalid_q <= cpu_rd_gnt;
      dma_rvalid_q <= dma_rd_gnt;
      if (cpu_rd_gnt) cpu_rdata_q <= mem_rdata;
      if (dma_rd_gnt) dma_rdata_q <= mem_rdata;
    end
  end

  assign cpu_rvalid = cpu_rvalid_q;
  assign dma_rvalid = dma_rvalid_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign dma_rdata  = dma_rdata_q;

endmodule
